muldiv_sched: RTL
=================

# muldiv_sched

Multi-cycle HI/LO multiply/divide scheduler for the MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from decode with operands already forwarded, sequences a latency-configurable multiplier and an iterative radix-2 divider, and owns the architectural HI/LO registers. Raises `stall` to hold decode while an operation is in flight. Cancels in-flight work on pipeline flush.

## Interface
- `MUL_LAT`, 3, multiply latency in cycles, legal 1..8.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op_valid` in 1: decode presents an op this cycle.
- `op_code` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- `op_a` in 32: rs value; dividend / multiplicand / MTHI/MTLO data.
- `op_b` in 32: rt value; divisor / multiplier.
- `flush` in 1: squash in-flight op and any op presented this cycle.
- `stall` out 1: op not accepted; decode must hold `op_valid`, `op_code`, `op_a`, `op_b` unchanged.
- `rdata` out 32: HI (MFHI) or LO (MFLO), combinational; valid when `op_valid & !stall` and op_code is 6/7.
- `busy` out 1: state != IDLE.
- `hi`, `lo` out 32 each: architectural HI/LO.

## Operation
- Accept = `op_valid & !stall & !flush`.
- `stall = op_valid & busy`; every op class stalls while busy, including MFHI/MFLO and MTHI/MTLO.
- States: IDLE, MUL, DIV, FIX.
- IDLE + accept MULT/MULTU: latch operands, counter = MUL_LAT-1, go MUL.
- MUL: counter decrements each cycle; at counter 0, write {hi,lo} = 64-bit product (signed for MULT, unsigned for MULTU) and go IDLE.
- IDLE + accept DIV/DIVU: latch |a|, |b| (signed) or raw operands (DIVU), record result signs, iteration count = 0, go DIV.
- DIV: one restoring-division step per cycle; after step 32, go FIX.
- FIX: LO = quotient negated if sign(a)^sign(b) (DIV only); HI = remainder negated if sign(a) (DIV only). Write hi/lo, go IDLE.
- Quotient truncates toward zero. 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0.
- Divide by zero, all variants: HI = op_a, LO = 0xFFFFFFFF. FIX skips sign correction when the divisor is zero.
- IDLE + accept MTHI/MTLO: write hi/lo = op_a at the accepting edge; stay IDLE.
- IDLE + MFHI/MFLO: `rdata` = hi/lo, no stall, no state change.
- `rdata` = hi when op_code is not 7; otherwise lo.
- `flush` at any edge: go IDLE, discard the partial result, leave hi/lo unchanged. An op presented with `flush=1` is not accepted. Flush in IDLE has no effect.
- `reset`: state IDLE, hi=lo=0, counters 0, so `stall`=0, `busy`=0, `rdata`=0.

## Timing
- Accept at edge k.
- MUL: hi/lo updated at edge k+MUL_LAT; `busy` high for MUL_LAT cycles.
- DIV: steps at edges k+1..k+32, hi/lo written at edge k+33; `busy` high for 33 cycles.
- Reset has priority over flush; flush has priority over completion. A flush on the completing edge discards the result.
- An MFHI held under stall returns the new hi in the first cycle `busy`=0, i.e. the cycle after the writing edge.
- MTHI/MTLO effects are visible on `hi`/`lo` and `rdata` in the cycle after accept.

## Configuration
- `MULDIV_DIV0_FAST_EN` defined: DIV/DIVU with op_b==0 skips DIV and FIX. Result is written at edge k+1, `busy` is high for 1 cycle.
- Undefined: divide by zero runs the full 33 cycles.
- Result values are identical in both builds.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003, MUL_LAT=3 -> `busy` for 3 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA at accept+3. MULTU of the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at accept+33. DIVU 7/2 -> lo=3, hi=1.
- DIV 0x12345678 / 0 -> hi=0x12345678, lo=0xFFFFFFFF. Completes at accept+33 without the macro, accept+1 with `MULDIV_DIV0_FAST_EN`.
- MFLO issued the cycle after a DIV accept -> `stall`=1 for 33 cycles, then `rdata`=new lo with `stall`=0.
- MTHI 0xDEADBEEF, then DIVU 10/3, then `flush` at accept+10 -> state IDLE next cycle, hi stays 0xDEADBEEF, lo unchanged. A subsequent MULTU is accepted with no stall.
- `reset` asserted mid-DIV -> next cycle hi=lo=0, `busy`=0, `stall`=0.

Source files
------------

// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide scheduler: sequences a MUL_LAT-cycle multiplier and a 32-step
// restoring divider, owns HI/LO, holds decode via stall while busy, cancels work on flush.
// Optional build macro MULDIV_DIV0_FAST_EN: divide-by-zero completes one cycle after accept.
module muldiv_sched #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  // quo_q doubles as the multiplicand, dvs_q as the multiplier while in S_MUL.
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        sgn_q, sgn_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d;

  logic               accept, a_neg, b_neg, b_zero;
  logic signed [63:0] mul_a, mul_b, mul_p;
  logic [32:0]        shifted, diff;

  assign busy   = (state_q != S_IDLE);
  assign stall  = op_valid & busy;
  assign accept = op_valid & ~stall & ~flush;
  assign rdata  = (op_code == OP_MFLO) ? lo_q : hi_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

  // Datapath helpers: sign-extended product and one restoring-division trial subtract.
  always_comb begin
    mul_a   = {{32{sgn_q & quo_q[31]}}, quo_q};
    mul_b   = {{32{sgn_q & dvs_q[31]}}, dvs_q};
    mul_p   = mul_a * mul_b;
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    a_neg   = (op_code == OP_DIV) & op_a[31];
    b_neg   = (op_code == OP_DIV) & op_b[31];
    b_zero  = (op_b == 32'd0);
  end

  // Next-state and datapath update; flush beats every completion and leaves HI/LO alone.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    div0_d  = div0_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_code)
            OP_MULT, OP_MULTU: begin
              quo_d   = op_a;
              dvs_d   = op_b;
              sgn_d   = (op_code == OP_MULT);
              cnt_d   = 6'(MUL_LAT - 1);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor keeps the raw dividend so the remainder ends up equal to op_a.
              quo_d   = (a_neg && !b_zero) ? (32'd0 - op_a) : op_a;
              dvs_d   = b_neg ? (32'd0 - op_b) : op_b;
              q_neg_d = a_neg ^ b_neg;
              r_neg_d = a_neg;
              div0_d  = b_zero;
              rem_d   = 32'd0;
              cnt_d   = 6'd0;
`ifdef MULDIV_DIV0_FAST_EN
              if (b_zero) begin
                rem_d   = op_a;
                state_d = S_FIX;
              end else begin
                state_d = S_DIV;
              end
`else
              state_d = S_DIV;
`endif
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 6'd0) begin
          hi_d    = mul_p[63:32];
          lo_d    = mul_p[31:0];
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = diff[32] ? shifted[31:0] : diff[31:0];
          quo_d = {quo_q[30:0], ~diff[32]};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          if (div0_q) begin
            hi_d = rem_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = r_neg_q ? (32'd0 - rem_q) : rem_q;
            lo_d = q_neg_q ? (32'd0 - quo_q) : quo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset clearing HI/LO and all counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      div0_q  <= div0_d;
    end
  end

endmodule
